// File: rtl/ctrl_sequencer_pkg.sv
// Shared types for the control sequencer: opcode map, FSM states and the
// bundle of datapath enables produced by the decoder.
package ctrl_sequencer_pkg;

    localparam int DEFAULT_MEM_LAT = 1;
    localparam int DEFAULT_CNT_W   = 16;
    localparam int WAIT_W          = 3;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SHL   = 4'd5,
        OP_SHR   = 4'd6,
        OP_INC   = 4'd7,
        OP_DEC   = 4'd8,
        OP_STR   = 4'd9,
        OP_CLR   = 4'd10,
        OP_LOAD  = 4'd11,
        OP_STORE = 4'd12,
        OP_HALT  = 4'd13,
        OP_LUT   = 4'd14,
        OP_ILL   = 4'd15
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MEMWAIT,
        S_HALT
    } ctrl_state_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic acc_write;
        logic is_mem;
        logic lookup;
    } ctrl_t;

    localparam int    CTRL_W    = $bits(ctrl_t);
    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/ctrl_sequencer_decode.sv
// Combinational opcode -> datapath enable table, before any state gating.
module ctrl_decode
    import ctrl_sequencer_pkg::*;
(
    input  logic [3:0]        opcode,
    output logic [CTRL_W-1:0] ctrl
);

    ctrl_t c;

    // Halt and the reserved opcode drive nothing; the sequencer decides their fate.
    always_comb begin
        c = CTRL_NONE;
        case (op_t'(opcode))
            OP_STR:   c.reg_write = 1'b1;
            OP_LOAD: begin
                c.mem_read  = 1'b1;
                c.is_mem    = 1'b1;
                c.acc_write = 1'b1;
            end
            OP_STORE: c.mem_write = 1'b1;
            OP_LUT: begin
                c.acc_write = 1'b1;
                c.lookup    = 1'b1;
            end
            OP_HALT, OP_ILL: c = CTRL_NONE;
            default:  c.acc_write = 1'b1;
        endcase
    end

    assign ctrl = c;

endmodule

// File: rtl/ctrl_sequencer.sv
// Clocked control sequencer: decode, multi-cycle loads, run/halt and retire count.
// Optional illegal-opcode trap enabled by defining CTRL_ILLEGAL_TRAP_EN.
module ctrl_sequencer
    import ctrl_sequencer_pkg::*;
#(
    parameter int INSTR_W = 9,
    parameter int OP_W    = 4,
    parameter int MEM_LAT = DEFAULT_MEM_LAT,
    parameter int BR_COND = 0,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [INSTR_W-1:0] Instruction,
    input  logic               ZERO,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic               REG_WRITE,
    output logic               ACC_WRITE,
    output logic               IS_MEM,
    output logic               LOOKUP,
    output logic               pc_en,
    output logic               pc_init,
    output logic               branch,
    output logic               illegal,
    output logic               done,
    output logic [CNT_W-1:0]   retired
);

    ctrl_state_t       state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
    logic [CNT_W-1:0]  retired_q;
    logic [3:0]        opcode;
    logic [CTRL_W-1:0] dec_bits;
    ctrl_t             dec, en;
    logic              is_branch, br_taken;
    logic              retire, clear_retired;
    logic              pc_en_c, pc_init_c, branch_c, done_c;
    logic              illegal_c;
    logic              live;
    logic              unused_operand;

    assign opcode         = 4'(Instruction[INSTR_W-2 -: OP_W]);
    assign is_branch      = Instruction[INSTR_W-1];
    assign br_taken       = (BR_COND != 0) ? ZERO : 1'b1;
    assign unused_operand = ^Instruction[INSTR_W-OP_W-2:0];

    ctrl_decode u_decode (
        .opcode (opcode),
        .ctrl   (dec_bits)
    );

    assign dec = ctrl_t'(dec_bits);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            retired_q <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (clear_retired)
                retired_q <= '0;
            else if (retire)
                retired_q <= retired_q + CNT_W'(1);
        end
    end

    // An abort (Start outside IDLE/HALT) suppresses every enable and the retire.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        en            = CTRL_NONE;
        pc_en_c       = 1'b0;
        pc_init_c     = 1'b0;
        branch_c      = 1'b0;
        done_c        = 1'b0;
        illegal_c     = 1'b0;
        retire        = 1'b0;
        clear_retired = 1'b0;
        unique case (state)
            S_IDLE: begin
                pc_init_c = 1'b1;
                if (Start) begin
                    state_next    = S_EXEC;
                    clear_retired = 1'b1;
                end
            end
            S_EXEC: begin
                if (Start) begin
                    state_next = S_IDLE;
                end else if (is_branch) begin
                    branch_c = br_taken;
                    pc_en_c  = ~br_taken;
                    retire   = 1'b1;
                end else begin
                    case (op_t'(opcode))
                        OP_LOAD: begin
                            en = dec;
                            if (MEM_LAT == 0) begin
                                pc_en_c = 1'b1;
                                retire  = 1'b1;
                            end else begin
                                en.acc_write  = 1'b0;
                                wait_cnt_next = WAIT_W'(MEM_LAT);
                                state_next    = S_MEMWAIT;
                            end
                        end
                        OP_HALT: begin
                            done_c     = 1'b1;
                            retire     = 1'b1;
                            state_next = S_HALT;
                        end
`ifdef CTRL_ILLEGAL_TRAP_EN
                        OP_ILL: begin
                            illegal_c  = 1'b1;
                            done_c     = 1'b1;
                            state_next = S_HALT;
                        end
`endif
                        default: begin
                            en      = dec;
                            pc_en_c = 1'b1;
                            retire  = 1'b1;
                        end
                    endcase
                end
            end
            S_MEMWAIT: begin
                if (Start) begin
                    state_next = S_IDLE;
                end else begin
                    en.mem_read   = 1'b1;
                    en.is_mem     = 1'b1;
                    wait_cnt_next = wait_cnt - WAIT_W'(1);
                    if (wait_cnt == WAIT_W'(1)) begin
                        en.acc_write = 1'b1;
                        pc_en_c      = 1'b1;
                        retire       = 1'b1;
                        state_next   = S_EXEC;
                    end
                end
            end
            S_HALT: begin
                done_c = 1'b1;
                if (Start)
                    state_next = S_IDLE;
            end
        endcase
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge Clk) begin
        if (Reset || Start)
            illegal_q <= 1'b0;
        else if (illegal_c)
            illegal_q <= 1'b1;
    end

    assign illegal = live & (illegal_c | illegal_q);
`else
    assign illegal = 1'b0;
`endif

    // Outputs read as all-zero for as long as Reset is held.
    assign live      = ~Reset;
    assign MEM_READ  = live & en.mem_read;
    assign MEM_WRITE = live & en.mem_write;
    assign REG_WRITE = live & en.reg_write;
    assign ACC_WRITE = live & en.acc_write;
    assign IS_MEM    = live & en.is_mem;
    assign LOOKUP    = live & en.lookup;
    assign pc_en     = live & pc_en_c;
    assign pc_init   = live & pc_init_c;
    assign branch    = live & branch_c;
    assign done      = live & done_c;
    assign retired   = live ? retired_q : '0;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer (MEM_LAT=2, BR_COND=1, CNT_W=4).
// Follows CTRL_ILLEGAL_TRAP_EN so the same bench covers both builds.
module tb_ctrl_sequencer;

    localparam int INSTR_W = 9;
    localparam int OP_W    = 4;
    localparam int MEM_LAT = 2;
    localparam int BR_COND = 1;
    localparam int CNT_W   = 4;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_EXEC = 1;
    localparam int M_WAIT = 2;
    localparam int M_HALT = 3;

    logic               Clk = 1'b0;
    logic               Reset = 1'b1;
    logic               Start = 1'b0;
    logic [INSTR_W-1:0] Instruction = '0;
    logic               ZERO = 1'b0;
    logic               MEM_READ, MEM_WRITE, REG_WRITE, ACC_WRITE, IS_MEM, LOOKUP;
    logic               pc_en, pc_init, branch, illegal, done;
    logic [CNT_W-1:0]   retired;

    int          checkCount = 0;
    int          errorCount = 0;
    logic [14:0] exp_q[$];
    string       tag_q[$];

    int          m_mode = M_IDLE;
    int          m_wait = 0;
    logic [3:0]  m_retired = '0;
    logic        m_illegal = 1'b0;

    ctrl_sequencer #(
        .INSTR_W (INSTR_W),
        .OP_W    (OP_W),
        .MEM_LAT (MEM_LAT),
        .BR_COND (BR_COND),
        .CNT_W   (CNT_W)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Instruction (Instruction),
        .ZERO        (ZERO),
        .MEM_READ    (MEM_READ),
        .MEM_WRITE   (MEM_WRITE),
        .REG_WRITE   (REG_WRITE),
        .ACC_WRITE   (ACC_WRITE),
        .IS_MEM      (IS_MEM),
        .LOOKUP      (LOOKUP),
        .pc_en       (pc_en),
        .pc_init     (pc_init),
        .branch      (branch),
        .illegal     (illegal),
        .done        (done),
        .retired     (retired)
    );

    always #5 Clk = ~Clk;

    function automatic logic [8:0] mk(input logic br, input logic [3:0] op, input logic [3:0] operand);
        return {br, op, operand};
    endfunction

    task automatic checkOutput(input string tag, input logic [14:0] actual, input logic [14:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, actual, expected);
        end
    endtask

    // Reference behaviour: outputs for this cycle, then advance to the next cycle.
    task automatic modelStep(input logic rst, input logic st, input logic [8:0] instr,
                             input logic zero, output logic [14:0] e);
        logic mr, mw, rw, aw, im, lk, pe, pi, br, il, dn;
        logic [3:0] op;
        logic [3:0] ret_now;
        {mr, mw, rw, aw, im, lk, pe, pi, br, il, dn} = '0;
        op      = instr[7:4];
        ret_now = m_retired;
        if (rst) begin
            ret_now   = '0;
            m_mode    = M_IDLE;
            m_wait    = 0;
            m_retired = '0;
            m_illegal = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    pi = 1'b1;
                    if (st) begin
                        m_mode    = M_EXEC;
                        m_retired = '0;
                    end
                end
                M_HALT: begin
                    dn = 1'b1;
                    il = m_illegal;
                    if (st) begin
                        m_mode    = M_IDLE;
                        m_illegal = 1'b0;
                    end
                end
                M_WAIT: begin
                    if (st) begin
                        m_mode = M_IDLE;
                    end else begin
                        mr = 1'b1;
                        im = 1'b1;
                        m_wait--;
                        if (m_wait == 0) begin
                            aw = 1'b1;
                            pe = 1'b1;
                            m_retired++;
                            m_mode = M_EXEC;
                        end
                    end
                end
                default: begin
                    if (st) begin
                        m_mode = M_IDLE;
                    end else if (instr[8]) begin
                        br = (BR_COND != 0) ? zero : 1'b1;
                        pe = ~br;
                        m_retired++;
                    end else if (op == 4'd11) begin
                        mr = 1'b1;
                        im = 1'b1;
                        if (MEM_LAT == 0) begin
                            aw = 1'b1;
                            pe = 1'b1;
                            m_retired++;
                        end else begin
                            m_wait = MEM_LAT;
                            m_mode = M_WAIT;
                        end
                    end else if (op == 4'd13) begin
                        dn = 1'b1;
                        m_retired++;
                        m_mode = M_HALT;
                    end else if (op == 4'd15 && TRAP) begin
                        il = 1'b1;
                        dn = 1'b1;
                        m_illegal = 1'b1;
                        m_mode = M_HALT;
                    end else begin
                        pe = 1'b1;
                        m_retired++;
                        case (op)
                            4'd9:    rw = 1'b1;
                            4'd12:   mw = 1'b1;
                            4'd14: begin
                                aw = 1'b1;
                                lk = 1'b1;
                            end
                            4'd15:   ;
                            default: aw = 1'b1;
                        endcase
                    end
                end
            endcase
        end
        e = {mr, mw, rw, aw, im, lk, pe, pi, br, il, dn, ret_now};
    endtask

    task automatic applyStimulus(input string tag, input logic rst, input logic st,
                                 input logic [8:0] instr, input logic zero);
        logic [14:0] e;
        @(posedge Clk);
        #1;
        Reset       = rst;
        Start       = st;
        Instruction = instr;
        ZERO        = zero;
        modelStep(rst, st, instr, zero, e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            logic [14:0] e;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checkOutput(t, {MEM_READ, MEM_WRITE, REG_WRITE, ACC_WRITE, IS_MEM, LOOKUP,
                            pc_en, pc_init, branch, illegal, done, retired}, e);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d", checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] op;
        applyStimulus("reset0", 1'b1, 1'b0, 9'd0, 1'b0);
        applyStimulus("reset1", 1'b1, 1'b0, 9'd0, 1'b0);
        applyStimulus("reset_wins_start", 1'b1, 1'b1, 9'd0, 1'b0);
        applyStimulus("idle_after_reset", 1'b0, 1'b0, 9'd0, 1'b0);
        applyStimulus("start", 1'b0, 1'b1, 9'd0, 1'b0);
        applyStimulus("op0_acc", 1'b0, 1'b0, mk(1'b0, 4'd0, 4'd3), 1'b0);
        applyStimulus("op9_reg", 1'b0, 1'b0, mk(1'b0, 4'd9, 4'd1), 1'b0);
        applyStimulus("op12_store", 1'b0, 1'b0, mk(1'b0, 4'd12, 4'd2), 1'b0);
        applyStimulus("op14_lookup", 1'b0, 1'b0, mk(1'b0, 4'd14, 4'd5), 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus("load_cycle", 1'b0, 1'b0, mk(1'b0, 4'd11, 4'd7), 1'b0);
        applyStimulus("branch_not_taken", 1'b0, 1'b0, mk(1'b1, 4'd3, 4'd9), 1'b0);
        applyStimulus("branch_taken", 1'b0, 1'b0, mk(1'b1, 4'd3, 4'd9), 1'b1);

        for (int i = 0; i < 20; i++) begin
            op = 4'($urandom_range(0, 14));
            if (op == 4'd11 || op == 4'd13)
                op = 4'd14;
            applyStimulus("random_op", 1'b0, 1'b0,
                          mk(1'($urandom_range(0, 1)), op, 4'($urandom_range(0, 15))),
                          1'($urandom_range(0, 1)));
        end

        applyStimulus("abort_exec", 1'b0, 1'b1, mk(1'b0, 4'd12, 4'd0), 1'b0);
        applyStimulus("idle_after_abort", 1'b0, 1'b0, 9'd0, 1'b0);
        applyStimulus("restart_a", 1'b0, 1'b1, 9'd0, 1'b0);
        applyStimulus("load_issue", 1'b0, 1'b0, mk(1'b0, 4'd11, 4'd0), 1'b0);
        applyStimulus("abort_memwait", 1'b0, 1'b1, mk(1'b0, 4'd11, 4'd0), 1'b0);
        applyStimulus("idle_after_wait_abort", 1'b0, 1'b0, 9'd0, 1'b0);
        applyStimulus("restart_b", 1'b0, 1'b1, 9'd0, 1'b0);

        for (int i = 0; i < 17; i++)
            applyStimulus("wrap_count", 1'b0, 1'b0, mk(1'b0, 4'd1, 4'(i)), 1'b0);
        applyStimulus("halt_op", 1'b0, 1'b0, mk(1'b0, 4'd13, 4'd0), 1'b0);
        for (int i = 0; i < 10; i++)
            applyStimulus("halt_hold", 1'b0, 1'b0, mk(1'b0, 4'($urandom_range(0, 15)), 4'd0), 1'b0);
        applyStimulus("halt_start", 1'b0, 1'b1, 9'd0, 1'b0);
        applyStimulus("idle_after_halt", 1'b0, 1'b0, 9'd0, 1'b0);

        applyStimulus("restart_c", 1'b0, 1'b1, 9'd0, 1'b0);
        applyStimulus("op15", 1'b0, 1'b0, mk(1'b0, 4'd15, 4'd0), 1'b0);
        applyStimulus("after_op15_a", 1'b0, 1'b0, mk(1'b0, 4'd2, 4'd0), 1'b0);
        applyStimulus("after_op15_b", 1'b0, 1'b0, mk(1'b0, 4'd9, 4'd0), 1'b0);
        applyStimulus("clear_op15", 1'b0, 1'b1, 9'd0, 1'b0);
        applyStimulus("idle_after_op15", 1'b0, 1'b0, 9'd0, 1'b0);

        applyStimulus("restart_d", 1'b0, 1'b1, 9'd0, 1'b0);
        applyStimulus("run_before_reset", 1'b0, 1'b0, mk(1'b0, 4'd4, 4'd0), 1'b0);
        applyStimulus("mid_reset", 1'b1, 1'b1, mk(1'b0, 4'd2, 4'd0), 1'b0);
        applyStimulus("idle_after_mid_reset", 1'b0, 1'b0, 9'd0, 1'b0);

        @(negedge Clk);
        #1;
        checkOutput("scoreboard_drained", 15'(exp_q.size()), 15'd0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
